// File: rtl/tt_dpll_pkg.sv
// Shared types and default constants for the DPLL acquisition/lock sequencer.
package tt_dpll_pkg;

    localparam int unsigned STATE_W          = 3;
    localparam int unsigned CNT_W_DEF        = 8;
    localparam int unsigned CLEAR_CYCLES_DEF = 4;
    localparam int unsigned COARSE_CNT_DEF   = 16;
    localparam int unsigned LOCK_CNT_DEF     = 64;
    localparam int unsigned UNLOCK_CNT_DEF   = 4;
    localparam int unsigned ACQ_TIMEOUT_DEF  = 200;
    localparam int unsigned RETRY_W_DEF      = 4;

    localparam logic [1:0] GAIN_OFF    = 2'b00;
    localparam logic [1:0] GAIN_COARSE = 2'b10;
    localparam logic [1:0] GAIN_FINE   = 2'b01;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

endpackage

// File: rtl/tt_sat_counter.sv
// Saturating up-counter with synchronous clear and a scan-shift mode.
// Scan shifts bit 0 toward the MSB; the MSB feeds the next chain element.
module tt_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scan_en,
    input  logic         scan_in,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         scan_out
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Counter register: scan shift overrides clear, clear overrides increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (scan_en) begin
            cnt <= {cnt[W-2:0], scan_in};
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign scan_out = cnt[W-1];

endmodule

// File: rtl/tt_dpll_lock_ctrl.sv
// DPLL acquisition and lock sequencer: clear, coarse acquire, fine track,
// locked, with loss-of-lock detection, timeout retry and a scan chain.
module tt_dpll_lock_ctrl
    import tt_dpll_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned CLEAR_CYCLES = CLEAR_CYCLES_DEF,
    parameter int unsigned COARSE_CNT   = COARSE_CNT_DEF,
    parameter int unsigned LOCK_CNT     = LOCK_CNT_DEF,
    parameter int unsigned UNLOCK_CNT   = UNLOCK_CNT_DEF,
    parameter int unsigned ACQ_TIMEOUT  = ACQ_TIMEOUT_DEF,
    parameter int unsigned RETRY_W      = RETRY_W_DEF
) (
    input  logic               o_clk_gen,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_up,
    input  logic               i_down,
    output logic               o_lpf_clear,
    output logic               o_lpf_hold,
    output logic [1:0]         o_gain_sel,
    output logic               o_locked,
    output logic               o_lost_lock,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic [2:0]         o_state,
    input  logic               i_scan_en,
    input  logic               i_scan_in,
    output logic               o_scan_out
);

    state_t             state;
    state_t             next_state;
    logic               activity;
    logic               state_chg;
    logic               retry_inc;
    logic               timeout;
    logic               coarse_hit;
    logic               lock_hit;
    logic               unlock_hit;
    logic [CNT_W-1:0]   quiet_cnt;
    logic [CNT_W-1:0]   act_cnt;
    logic [CNT_W-1:0]   timer;
    logic               quiet_so;
    logic               act_so;
    logic               timer_so;
    logic [RETRY_W-1:0] retry_cnt;
    logic               lost_lock;

    assign activity   = i_up | i_down;
    assign timeout    = (timer == CNT_W'(ACQ_TIMEOUT - 1));
    assign coarse_hit = (quiet_cnt == CNT_W'(COARSE_CNT - 1)) && !activity;
    assign lock_hit   = (quiet_cnt == CNT_W'(LOCK_CNT - 1)) && !activity;
    assign unlock_hit = (act_cnt == CNT_W'(UNLOCK_CNT - 1)) && activity;
    assign state_chg  = (next_state != state);

    // Next-state logic; priority is enable, then timeout, then advance, then unlock.
    always_comb begin
        next_state = state;
        retry_inc  = 1'b0;
        if (!i_enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    next_state = ST_CLEAR;
                ST_CLEAR: begin
                    if (timer == CNT_W'(CLEAR_CYCLES - 1)) next_state = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (timeout) begin
                        next_state = ST_CLEAR;
                        retry_inc  = 1'b1;
                    end else if (coarse_hit) begin
                        next_state = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (timeout) begin
                        next_state = ST_CLEAR;
                        retry_inc  = 1'b1;
                    end else if (lock_hit) begin
                        next_state = ST_LOCKED;
                    end else if (unlock_hit) begin
                        next_state = ST_ACQUIRE;
                    end
                end
                ST_LOCKED: begin
                    if (unlock_hit) next_state = ST_ACQUIRE;
                end
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // State register; scan shifts state[0] -> state[2].
    always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else if (i_scan_en) begin
            state <= state_t'({state[1:0], i_scan_in});
        end else begin
            state <= next_state;
        end
    end

    tt_sat_counter #(.W(CNT_W)) u_quiet_cnt (
        .clk      (o_clk_gen),
        .rst_n    (i_rst_n),
        .scan_en  (i_scan_en),
        .scan_in  (state[2]),
        .clr      (activity | state_chg | !i_enable),
        .inc      (!activity),
        .cnt      (quiet_cnt),
        .scan_out (quiet_so)
    );

    tt_sat_counter #(.W(CNT_W)) u_act_cnt (
        .clk      (o_clk_gen),
        .rst_n    (i_rst_n),
        .scan_en  (i_scan_en),
        .scan_in  (quiet_so),
        .clr      (!activity | state_chg | !i_enable),
        .inc      (activity),
        .cnt      (act_cnt),
        .scan_out (act_so)
    );

    // Phase timer keeps running across ACQUIRE->TRACK so the timeout spans both.
    tt_sat_counter #(.W(CNT_W)) u_timer (
        .clk      (o_clk_gen),
        .rst_n    (i_rst_n),
        .scan_en  (i_scan_en),
        .scan_in  (act_so),
        .clr      ((state_chg && !((state == ST_ACQUIRE) && (next_state == ST_TRACK)))
                   | !i_enable),
        .inc      (1'b1),
        .cnt      (timer),
        .scan_out (timer_so)
    );

    // Retry counter and registered loss-of-lock pulse, tail of the scan chain.
    always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retry_cnt <= '0;
            lost_lock <= 1'b0;
        end else if (i_scan_en) begin
            retry_cnt <= {retry_cnt[RETRY_W-2:0], timer_so};
            lost_lock <= retry_cnt[RETRY_W-1];
        end else begin
            if (retry_inc && (retry_cnt != '1)) retry_cnt <= retry_cnt + RETRY_W'(1);
            lost_lock <= (state == ST_LOCKED) && (next_state == ST_ACQUIRE);
        end
    end

    // Loop-filter controls decoded from the current state.
    always_comb begin
        o_lpf_clear = 1'b0;
        o_lpf_hold  = 1'b0;
        o_gain_sel  = GAIN_OFF;
        o_locked    = 1'b0;
        case (state)
            ST_IDLE:    o_lpf_hold  = 1'b1;
            ST_CLEAR:   o_lpf_clear = 1'b1;
            ST_ACQUIRE: o_gain_sel  = GAIN_COARSE;
            ST_TRACK:   o_gain_sel  = GAIN_FINE;
            ST_LOCKED: begin
                o_gain_sel = GAIN_FINE;
                o_locked   = 1'b1;
            end
            default:    o_gain_sel  = GAIN_OFF;
        endcase
    end

    assign o_lost_lock = lost_lock;
    assign o_retry_cnt = retry_cnt;
    assign o_state     = state;
    assign o_scan_out  = lost_lock;

endmodule
